seven_segment_scanner: RTL and testbench

- Time-multiplexed digit scanner that sits directly upstream of seven_segment_decoder on a common-anode multi-digit display.
- Holds a frame of NUM_DIGITS hex nibbles and steps through one digit per refresh slot.
- For the active digit it presents the nibble on digit_data, which feeds the decoder's data_in. It also drives the active-low anode strobe and the decimal-point bit, which is merged into segments[7].

---
 rtl/seven_segment_scanner.sv | 109 ++++++++++
 tb/tb_seven_segment_scanner.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scanner.sv
// Multiplexed digit scanner feeding seven_segment_decoder on a common-anode display.
// Optional leading-zero blanking: define SEVEN_SEGMENT_SCANNER_LZB_EN.
module seven_segment_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [4*NUM_DIGITS-1:0]       value,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [NUM_DIGITS-1:0]         blank,
  output logic [3:0]                    digit_data,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_sel,
  output logic [NUM_DIGITS-1:0]         anodes,
  output logic                          dp_n
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SEL_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]                cnt_q;
  logic [SEL_W-1:0]                idx_q;
  logic                            lit_q;
  logic [NUM_DIGITS-1:0][3:0]      value_q;
  logic [NUM_DIGITS-1:0]           dp_q;
  logic [NUM_DIGITS-1:0]           blank_q;

  logic [NUM_DIGITS-1:0][3:0]      value_nib;
  logic [NUM_DIGITS-1:0]           blank_snap;
  logic                            tick;
  logic                            wrap;
  logic [SEL_W-1:0]                idx_nxt;
  logic [NUM_DIGITS-1:0][3:0]      frame_nib;
  logic [NUM_DIGITS-1:0]           frame_dp;
  logic [NUM_DIGITS-1:0]           frame_blank;
  logic [NUM_DIGITS-1:0]           anodes_nxt;

  assign value_nib = value;

`ifdef SEVEN_SEGMENT_SCANNER_LZB_EN
  // zero_above[i]: every digit from i up to the MSD is zero
  logic [NUM_DIGITS:1]   zero_above;
  logic [NUM_DIGITS-1:0] lzb;
  assign zero_above[NUM_DIGITS] = 1'b1;
  assign lzb[0]                 = 1'b0;
  for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lzb
    assign zero_above[gi] = zero_above[gi+1] & (value_nib[gi] == 4'h0);
    assign lzb[gi]        = zero_above[gi];
  end
  assign blank_snap = blank | lzb;
`else
  assign blank_snap = blank;
`endif

  assign tick    = en & (cnt_q == CNT_LAST);
  assign wrap    = (idx_q == IDX_LAST);
  assign idx_nxt = wrap ? '0 : idx_q + SEL_W'(1);

  // On the wrap tick the new frame is shown in the same edge it is captured
  assign frame_nib   = wrap ? value_nib  : value_q;
  assign frame_dp    = wrap ? dp_in      : dp_q;
  assign frame_blank = wrap ? blank_snap : blank_q;

  // lit_q keeps the post-reset first slot dark until the first tick
  always_comb begin
    anodes_nxt = '1;
    if (en) begin
      if (tick) begin
        if (!frame_blank[idx_nxt]) anodes_nxt[idx_nxt] = 1'b0;
      end else if (lit_q && !blank_q[idx_q]) begin
        anodes_nxt[idx_q] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= IDX_LAST;
      lit_q      <= 1'b0;
      value_q    <= '0;
      dp_q       <= '0;
      blank_q    <= '0;
      digit_data <= 4'h0;
      digit_sel  <= '0;
      dp_n       <= 1'b1;
      anodes     <= '1;
    end else begin
      if (en) cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
      if (tick) begin
        idx_q      <= idx_nxt;
        lit_q      <= 1'b1;
        digit_sel  <= idx_nxt;
        digit_data <= frame_nib[idx_nxt];
        dp_n       <= ~frame_dp[idx_nxt];
        if (wrap) begin
          value_q <= value_nib;
          dp_q    <= dp_in;
          blank_q <= blank_snap;
        end
      end
      anodes <= anodes_nxt;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed scoreboard bench for seven_segment_scanner (4 digits / div 4, plus 2 digits / div 1).
module tb_seven_segment_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b1;
  logic [15:0] value = 16'h1234;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank = 4'h0;
  logic [3:0]  digit_data;
  logic [1:0]  digit_sel;
  logic [3:0]  anodes;
  logic        dp_n;

  logic [7:0]  value1 = 8'h9E;
  logic [1:0]  dp_in1 = 2'b10;
  logic [1:0]  blank1 = 2'b00;
  logic [3:0]  digit_data1;
  logic        digit_sel1;
  logic [1:0]  anodes1;
  logic        dp_n1;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] dd;
    logic [1:0] sel;
    logic       dp;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  seven_segment_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .value(value), .dp_in(dp_in), .blank(blank),
    .digit_data(digit_data), .digit_sel(digit_sel), .anodes(anodes), .dp_n(dp_n)
  );

  seven_segment_scanner #(.NUM_DIGITS(2), .REFRESH_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .value(value1), .dp_in(dp_in1), .blank(blank1),
    .digit_data(digit_data1), .digit_sel(digit_sel1), .anodes(anodes1), .dp_n(dp_n1)
  );

  task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] an, input logic [3:0] dd, input logic [1:0] sel,
                      input logic dp, input int n);
    exp_t e;
    e = '{an: an, dd: dd, sel: sel, dp: dp};
    repeat (n) q.push_back(e);
  endtask

  task automatic drain(input string tag);
    exp_t e;
    while (q.size() > 0) begin
      @(posedge clk);
      #1;
      e = q.pop_front();
      check(tag, {anodes, digit_data, digit_sel, dp_n}, e);
    end
  endtask

`ifdef SEVEN_SEGMENT_SCANNER_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  initial begin
    #2 rst_n = 1'b0;
    #1 check("reset", {anodes, digit_data, digit_sel, dp_n}, {4'b1111, 4'h0, 2'd0, 1'b1});
    @(negedge clk) rst_n = 1'b1;

    // basic scan: dark first slot, then 4,3,2,1 and back to 4
    push(4'b1111, 4'h0, 2'd0, 1'b1, 3);
    push(4'b1110, 4'h4, 2'd0, 1'b1, 4);
    push(4'b1101, 4'h3, 2'd1, 1'b1, 4);
    push(4'b1011, 4'h2, 2'd2, 1'b1, 4);
    push(4'b0111, 4'h1, 2'd3, 1'b1, 4);
    push(4'b1110, 4'h4, 2'd0, 1'b1, 4);
    push(4'b1101, 4'h3, 2'd1, 1'b1, 4);
    push(4'b1011, 4'h2, 2'd2, 1'b1, 1);
    drain("scan");

    // mid-frame value change must not tear the current frame
    value = 16'hABCD;
    push(4'b1011, 4'h2, 2'd2, 1'b1, 3);
    push(4'b0111, 4'h1, 2'd3, 1'b1, 4);
    push(4'b1110, 4'hD, 2'd0, 1'b1, 4);
    push(4'b1101, 4'hC, 2'd1, 1'b1, 4);
    push(4'b1011, 4'hB, 2'd2, 1'b1, 4);
    push(4'b0111, 4'hA, 2'd3, 1'b1, 1);
    drain("snapshot");

    // decimal point on digit 1, blank on digit 3
    dp_in = 4'b0010;
    blank = 4'b1000;
    push(4'b0111, 4'hA, 2'd3, 1'b1, 3);
    push(4'b1110, 4'hD, 2'd0, 1'b1, 4);
    push(4'b1101, 4'hC, 2'd1, 1'b0, 4);
    push(4'b1011, 4'hB, 2'd2, 1'b1, 4);
    push(4'b1111, 4'hA, 2'd3, 1'b1, 4);
    push(4'b1110, 4'hD, 2'd0, 1'b1, 2);
    drain("dp_blank");

    // en low mid-slot for 10 cycles, then finish the remaining 2 cycles
    en = 1'b0;
    push(4'b1111, 4'hD, 2'd0, 1'b1, 10);
    drain("en_off");
    en = 1'b1;
    push(4'b1110, 4'hD, 2'd0, 1'b1, 2);
    push(4'b1101, 4'hC, 2'd1, 1'b0, 4);
    push(4'b1011, 4'hB, 2'd2, 1'b1, 1);
    drain("en_resume");

    // asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1 check("async_reset", {anodes, digit_data, digit_sel, dp_n}, {4'b1111, 4'h0, 2'd0, 1'b1});
    @(negedge clk) rst_n = 1'b1;
    push(4'b1111, 4'h0, 2'd0, 1'b1, 3);
    push(4'b1110, 4'hD, 2'd0, 1'b1, 4);
    push(4'b1101, 4'hC, 2'd1, 1'b0, 4);
    push(4'b1011, 4'hB, 2'd2, 1'b1, 4);
    push(4'b1111, 4'hA, 2'd3, 1'b1, 4);
    drain("post_reset");

    // leading zeros: blanked only with the optional feature
    rst_n = 1'b0;
    value = 16'h0050;
    dp_in = 4'h0;
    blank = 4'h0;
    @(negedge clk) rst_n = 1'b1;
    push(4'b1111, 4'h0, 2'd0, 1'b1, 3);
    push(4'b1110, 4'h0, 2'd0, 1'b1, 4);
    push(4'b1101, 4'h5, 2'd1, 1'b1, 4);
    push(LZB ? 4'b1111 : 4'b1011, 4'h0, 2'd2, 1'b1, 4);
    push(LZB ? 4'b1111 : 4'b0111, 4'h0, 2'd3, 1'b1, 1);
    drain("lzb_0050");
    value = 16'h0000;
    push(LZB ? 4'b1111 : 4'b0111, 4'h0, 2'd3, 1'b1, 3);
    push(4'b1110, 4'h0, 2'd0, 1'b1, 4);
    push(LZB ? 4'b1111 : 4'b1101, 4'h0, 2'd1, 1'b1, 4);
    push(LZB ? 4'b1111 : 4'b1011, 4'h0, 2'd2, 1'b1, 4);
    push(LZB ? 4'b1111 : 4'b0111, 4'h0, 2'd3, 1'b1, 4);
    drain("lzb_0000");

    // REFRESH_DIV=1, two digits: a tick on every enabled cycle
    rst_n = 1'b0;
    #1 check("div1_reset", {3'b0, anodes1, digit_data1, digit_sel1, dp_n1},
             {3'b0, 2'b11, 4'h0, 1'b0, 1'b1});
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (i % 2 == 0)
        check("div1_d0", {3'b0, anodes1, digit_data1, digit_sel1, dp_n1},
              {3'b0, 2'b10, 4'hE, 1'b0, 1'b1});
      else
        check("div1_d1", {3'b0, anodes1, digit_data1, digit_sel1, dp_n1},
              {3'b0, 2'b01, 4'h9, 1'b1, 1'b0});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
